// File: rtl/uart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// uart_bus_arbiter
//
// Shares one buffered UART register bus between several clients. Each client
// asks for one TX or RX word. The arbiter grants round-robin, reads the UART
// status register, and performs the transfer only when it can succeed. When it
// cannot, the client stays pending and the next client gets its turn. A
// successful transfer ends with a one-cycle ack and, for RX, the received word.
//
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   req_valid[r]       per-client request, held until ack
//   req_is_rx[r]       per-client operation: 1 = RX, 0 = TX
//   req_data[r*w]      per-client TX word, client i at [i*width +: width]
//   ack[r]             one-hot completion pulse
//   resp_data[w]       RX word in the ack cycle of an RX request, else 0
//   busy               high in every state except IDLE
//   bus_address        UART register address
//   bus_read_enable    UART consumes bus_data_in (TX push)
//   bus_write_enable   UART drives bus_data_out next cycle
//   bus_data_in        word presented to the UART
//   bus_data_out       word returned by the UART
// -----------------------------------------------------------------------------
module uart_bus_arbiter #(
   parameter int requesters     = 2,
   parameter int width          = 8,
   parameter int address_width  = 8,
   parameter int rx_address     = 3,
   parameter int tx_address     = 4,
   parameter int status_address = 5
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [requesters-1:0]         req_valid,
   input  logic [requesters-1:0]         req_is_rx,
   input  logic [requesters*width-1:0]   req_data,
   output logic [requesters-1:0]         ack,
   output logic [width-1:0]              resp_data,
   output logic                          busy,
   output logic [address_width-1:0]      bus_address,
   output logic                          bus_read_enable,
   output logic                          bus_write_enable,
   output logic [width-1:0]              bus_data_in,
   input  logic [width-1:0]              bus_data_out
);

   localparam int idx_w = $clog2(requesters);

   typedef enum logic [2:0] {
      IDLE, STATUS_REQ, STATUS_CAP, XFER, RX_CAP, ACK
   } state_t;

   state_t             state, next_state;
   logic [idx_w-1:0]   pointer;
   logic [idx_w-1:0]   grant_idx;
   logic               op_rx;
   logic [width-1:0]   tx_data;
   logic [width-1:0]   rx_data;

   logic [idx_w-1:0]   cand;
   logic [idx_w-1:0]   winner;
   logic               winner_found;
   logic               winner_rx;
   logic [width-1:0]   winner_data;
   logic               op_possible;
   logic [idx_w-1:0]   next_pointer;

   // Round-robin scan starting at the pointer; the first pending client wins.
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner       = pointer;
      winner_found = 1'b0;
      cand         = '0;
      for (int off = 0; off < requesters; off++) begin
         cand = idx_w'((int'(pointer) + off) % requesters);
         if (!winner_found && req_valid[cand]) begin
            winner_found = 1'b1;
            winner       = cand;
         end
      end
   end

   // Constant-index mux keeps the winner's op and data selection simple.
   always_comb begin
      winner_rx   = 1'b0;
      winner_data = '0;
      for (int i = 0; i < requesters; i++) begin
         if (winner == idx_w'(i)) begin
            winner_rx   = req_is_rx[i];
            winner_data = req_data[i*width +: width];
         end
      end
   end

   // Status is consumed in the cycle the UART returns it.
   assign op_possible  = op_rx ? bus_data_out[1] : bus_data_out[0];
   assign next_pointer = (grant_idx == idx_w'(requesters - 1)) ? '0
                                                               : grant_idx + 1'b1;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop sees
   // the pre-edge values of the others, independent of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (winner_found) next_state = STATUS_REQ;
         STATUS_REQ: next_state = STATUS_CAP;
         STATUS_CAP: next_state = op_possible ? XFER : IDLE;
         XFER:       next_state = op_rx ? RX_CAP : ACK;
         RX_CAP:     next_state = ACK;
         ACK:        next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   // Grant, data and pointer registers. The pointer advances past the winner
   // both on success and on a blocked attempt, so a blocked client cannot
   // starve the others.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pointer   <= '0;
         grant_idx <= '0;
         op_rx     <= 1'b0;
         tx_data   <= '0;
         rx_data   <= '0;
      end else begin
         case (state)
            IDLE: if (winner_found) begin
               grant_idx <= winner;
               op_rx     <= winner_rx;
               tx_data   <= winner_data;
            end
            STATUS_CAP: if (!op_possible) pointer <= next_pointer;
            RX_CAP:     rx_data <= bus_data_out;
            ACK:        pointer <= next_pointer;
            default:    ;
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      ack              = '0;
      resp_data        = '0;
      busy             = (state != IDLE);
      bus_address      = '0;
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      bus_data_in      = '0;
      case (state)
         STATUS_REQ: begin
            bus_address      = address_width'(status_address);
            bus_write_enable = 1'b1;
         end
         XFER: begin
            if (op_rx) begin
               bus_address      = address_width'(rx_address);
               bus_write_enable = 1'b1;
            end else begin
               bus_address      = address_width'(tx_address);
               bus_read_enable  = 1'b1;
               bus_data_in      = tx_data;
            end
         end
         ACK: begin
            ack[grant_idx] = 1'b1;
            if (op_rx) resp_data = rx_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_arbiter
//
// Self-checking bench for uart_bus_arbiter with two clients and 8-bit words.
// A small behavioural UART answers status and RX reads one cycle after the
// read strobe and records every TX push.
// -----------------------------------------------------------------------------
module tb_uart_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_is_rx = '0;
   logic [15:0] req_data  = '0;
   logic [1:0]  ack;
   logic [7:0]  resp_data;
   logic        busy;
   logic [7:0]  bus_address;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic [7:0]  bus_data_in;
   logic [7:0]  bus_data_out = '0;

   int checks = 0;
   int errors = 0;
   bit mon_on = 1'b0;

   uart_bus_arbiter #(
      .requesters(2), .width(8), .address_width(8),
      .rx_address(3), .tx_address(4), .status_address(5)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_is_rx(req_is_rx), .req_data(req_data),
      .ack(ack), .resp_data(resp_data), .busy(busy),
      .bus_address(bus_address), .bus_read_enable(bus_read_enable),
      .bus_write_enable(bus_write_enable), .bus_data_in(bus_data_in),
      .bus_data_out(bus_data_out)
   );

   always #5 clock = ~clock;

   // Behavioural UART.
   logic [7:0] uart_status  = '0;
   logic [7:0] uart_rx_word = '0;
   logic [7:0] push_q[$];

   always @(posedge clock) begin
      if (bus_write_enable)
         bus_data_out <= (bus_address == 8'd5) ? uart_status :
                         (bus_address == 8'd3) ? uart_rx_word : 8'h00;
      if (bus_read_enable && bus_address == 8'd4)
         push_q.push_back(bus_data_in);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Bus rules, checked every cycle away from the clock edge.
   always @(negedge clock) begin
      if (mon_on && !reset) begin
         check("bus_enables_exclusive", 32'(bus_read_enable & bus_write_enable), 0);
         if (!bus_read_enable && !bus_write_enable)
            check("bus_idle_zero", {bus_address, bus_data_in}, 0);
         check("ack_onehot0", 32'($onehot0(ack)), 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] all_outputs();
      return {ack, resp_data, busy, bus_address, bus_read_enable,
              bus_write_enable, bus_data_in};
   endfunction

   task automatic do_reset();
      @(posedge clock); #1;
      reset     = 1'b1;
      req_valid = '0;
      #1 check("reset_outputs_zero", all_outputs(), 0);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic [1:0] mask;
      bit         is_rx;
      logic [7:0] data;
      logic [7:0] status;
      logic [7:0] rx_word;
      logic [1:0] exp_ack;
      logic [7:0] exp_resp;
      int         exp_lat;
   } vec_t;

   vec_t vecs[6];

   // One request from an idle arbiter; n counts edges after the request is set,
   // so n == 1 is STATUS_REQ, n == 3 is XFER and n == exp_lat is the ack cycle.
   task automatic run_vec(input vec_t v, input int k);
      int n;
      uart_status  = v.status;
      uart_rx_word = v.rx_word;
      req_is_rx    = v.is_rx ? v.mask : 2'b00;
      req_data     = v.mask[0] ? {~v.data, v.data} : {v.data, ~v.data};
      req_valid    = v.mask;
      n = 0;
      while (n < 12 && ack == 2'b00) begin
         @(posedge clock); #1;
         n++;
         if (n == 1) begin
            check($sformatf("vec%0d_status_we", k), 32'(bus_write_enable), 1);
            check($sformatf("vec%0d_status_addr", k), bus_address, 5);
         end
         if (n == 3) begin
            if (v.is_rx) begin
               check($sformatf("vec%0d_rx_we", k), 32'(bus_write_enable), 1);
               check($sformatf("vec%0d_rx_addr", k), bus_address, 3);
            end else begin
               check($sformatf("vec%0d_tx_re", k), 32'(bus_read_enable), 1);
               check($sformatf("vec%0d_tx_addr", k), bus_address, 4);
               check($sformatf("vec%0d_tx_data", k), bus_data_in, v.data);
            end
         end
         if (ack == 2'b00) check($sformatf("vec%0d_resp_idle", k), resp_data, 0);
      end
      check($sformatf("vec%0d_ack", k), ack, v.exp_ack);
      check($sformatf("vec%0d_resp", k), resp_data, v.exp_resp);
      check($sformatf("vec%0d_latency", k), n, v.exp_lat);
      req_valid = '0;
      @(posedge clock); #1;
      check($sformatf("vec%0d_resp_after", k), resp_data, 0);
      check($sformatf("vec%0d_ack_after", k), ack, 0);
      check($sformatf("vec%0d_busy_after", k), 32'(busy), 0);
   endtask

   initial begin
      logic [1:0] rr_exp_ack[4];
      logic [7:0] rr_exp_data[4];
      logic [1:0] ack_val[$];
      int         ack_cyc[$];
      bit         saw0, saw1, rx_acc;
      int         n;

      //          mask   rx  data   status rx_word ack    resp   lat
      vecs[0] = '{2'b01, 0, 8'h0A, 8'h01, 8'h00, 2'b01, 8'h00, 4};
      vecs[1] = '{2'b10, 1, 8'h00, 8'h02, 8'h3E, 2'b10, 8'h3E, 5};
      vecs[2] = '{2'b10, 0, 8'hFF, 8'h03, 8'h00, 2'b10, 8'h00, 4};
      vecs[3] = '{2'b01, 1, 8'h00, 8'h03, 8'hA5, 2'b01, 8'hA5, 5};
      vecs[4] = '{2'b01, 0, 8'h00, 8'h01, 8'h00, 2'b01, 8'h00, 4};
      vecs[5] = '{2'b10, 1, 8'h00, 8'h02, 8'h00, 2'b10, 8'h00, 5};
      rr_exp_ack  = '{2'b01, 2'b10, 2'b01, 2'b10};
      rr_exp_data = '{8'h11, 8'h22, 8'h11, 8'h22};

      mon_on = 1'b1;
      #12 check("reset_state", all_outputs(), 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // Single transfers.
      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // Round robin with both clients requesting TX continuously.
      do_reset();
      push_q.delete();
      uart_status = 8'h01;
      req_is_rx   = 2'b00;
      req_data    = {8'h22, 8'h11};
      req_valid   = 2'b11;
      for (int c = 1; c <= 40 && ack_val.size() < 4; c++) begin
         @(posedge clock); #1;
         if (ack != 2'b00) begin
            ack_val.push_back(ack);
            ack_cyc.push_back(c);
         end
      end
      req_valid = '0;
      check("rr_ack_count", ack_val.size(), 4);
      check("rr_push_count", push_q.size(), 4);
      for (int i = 0; i < ack_val.size(); i++)
         check($sformatf("rr_ack%0d", i), ack_val[i], rr_exp_ack[i]);
      for (int i = 0; i < push_q.size() && i < 4; i++)
         check($sformatf("rr_data%0d", i), push_q[i], rr_exp_data[i]);
      if (ack_cyc.size() > 0) check("rr_first_latency", ack_cyc[0], 4);
      for (int i = 1; i < ack_cyc.size(); i++)
         check($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
      repeat (2) @(posedge clock);
      #1;

      // Blocked RX on client0 must not hold up TX on client1.
      do_reset();
      push_q.delete();
      uart_status = 8'h01;
      req_is_rx   = 2'b01;
      req_data    = {8'h77, 8'h00};
      req_valid   = 2'b11;
      saw0 = 0; saw1 = 0; rx_acc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clock); #1;
         if (ack[1]) begin saw1 = 1; req_valid[1] = 1'b0; end
         if (ack[0]) saw0 = 1;
         if (bus_write_enable && bus_address == 8'd3) rx_acc = 1;
      end
      check("blk_client1_acked", 32'(saw1), 1);
      check("blk_client0_no_ack", 32'(saw0), 0);
      check("blk_no_rx_access", 32'(rx_acc), 0);
      check("blk_push_count", push_q.size(), 1);
      if (push_q.size() > 0) check("blk_push_data", push_q[0], 8'h77);
      uart_status  = 8'h03;
      uart_rx_word = 8'hC3;
      n = 0;
      while (n < 20 && ack == 2'b00) begin @(posedge clock); #1; n++; end
      check("blk_retry_ack", ack, 2'b01);
      check("blk_retry_resp", resp_data, 8'hC3);
      req_valid = '0;
      @(posedge clock); #1;

      // Pointer now points at client1, so client1 wins the next grant;
      // reset in XFER must abandon it and restart with client0.
      push_q.delete();
      uart_status = 8'h01;
      req_is_rx   = 2'b00;
      req_data    = {8'h6B, 8'h5A};
      req_valid   = 2'b11;
      repeat (3) begin @(posedge clock); #1; end
      check("mid_xfer_re", 32'(bus_read_enable), 1);
      check("mid_xfer_data", bus_data_in, 8'h6B);
      #2 reset = 1'b1;
      #1 check("mid_reset_async_zero", all_outputs(), 0);
      @(posedge clock); #1;
      check("mid_reset_held_zero", all_outputs(), 0);
      reset = 1'b0;
      n = 0;
      while (n < 12 && ack == 2'b00) begin
         @(posedge clock); #1;
         n++;
         if (n == 1) begin
            check("mid_restart_we", 32'(bus_write_enable), 1);
            check("mid_restart_addr", bus_address, 5);
         end
      end
      check("mid_restart_ack", ack, 2'b01);
      check("mid_restart_latency", n, 4);
      check("mid_push_count", push_q.size(), 1);
      if (push_q.size() > 0) check("mid_push_data", push_q[0], 8'h5A);
      req_valid = '0;
      @(posedge clock); #1;

      // Request data is latched at grant.
      do_reset();
      push_q.delete();
      uart_status = 8'h01;
      req_is_rx   = 2'b00;
      req_data    = {8'h00, 8'h55};
      req_valid   = 2'b01;
      n = 0;
      while (n < 12 && ack == 2'b00) begin
         @(posedge clock); #1;
         n++;
         if (n == 1) req_data[7:0] = 8'hAA;
         if (n == 3) check("stable_xfer_data", bus_data_in, 8'h55);
      end
      check("stable_ack", ack, 2'b01);
      if (push_q.size() > 0) check("stable_push_data", push_q[0], 8'h55);
      req_valid = '0;
      repeat (2) @(posedge clock);
      #1;

      mon_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_bus_arbiter.md
Name: uart_bus_arbiter

Overview:
- Shares one buffered UART register bus between `requesters` independent clients.
- Each client asks to send one word (TX) or receive one word (RX).
- The arbiter polls the UART status register, performs the transfer only when it can succeed, and returns an acknowledge (plus RX data) to the client.
- Sits between client logic and the buffered UART's address/enable/data bus; it is the only bus master.

Parameters:
- requesters, 2, number of clients (≥2); round-robin order 0..requesters-1
- width, 8, data word width; matches UART width
- address_width, 8, bus address width
- rx_address, 3, UART RX buffer address
- tx_address, 4, UART TX buffer address
- status_address, 5, UART status address; status bit0 = tx_ready (TX buffer not full), bit1 = rx_valid (RX buffer not empty)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  requesters  per-client request; held until ack
- req_is_rx  input  requesters  per-client op: 1 = RX, 0 = TX
- req_data  input  requesters*width  per-client TX word; client i occupies bits [i*width +: width]
- ack  output  requesters  one-hot, one-cycle completion pulse
- resp_data  output  width  RX word; valid only in the ack cycle of an RX request, otherwise 0
- busy  output  1  high in every state except IDLE
- bus_address  output  address_width  UART register address
- bus_read_enable  output  1  UART consumes bus_data_in at bus_address (TX push)
- bus_write_enable  output  1  UART drives bus_data_out from bus_address; data valid the following cycle
- bus_data_in  output  width  word presented to UART
- bus_data_out  input  width  word returned by UART

Behaviour:
- Reset (asynchronous, any state):
  - FSM → IDLE; priority pointer → 0.
  - All outputs 0; latched op, index, data and status cleared.
  - A transaction in progress is abandoned with no ack.
- All outputs are decoded from registered state only.
- IDLE:
  - Scan req_valid starting at the pointer, wrapping modulo requesters; first set bit wins.
  - Latch winner index g, req_is_rx[g] and req_data[g] → STATUS_REQ.
  - No request → stay in IDLE.
- STATUS_REQ (1 cycle): bus_address = status_address, bus_write_enable = 1 → STATUS_CAP.
- STATUS_CAP (1 cycle): capture bus_data_out.
  - If the op is possible (TX needs bit0, RX needs bit1) → XFER.
  - Otherwise → IDLE with pointer = (g+1) mod requesters; no ack. The client stays pending and is retried in its turn, so a blocked client cannot starve others.
- XFER (1 cycle):
  - TX: bus_address = tx_address, bus_read_enable = 1, bus_data_in = latched data → ACK.
  - RX: bus_address = rx_address, bus_write_enable = 1 → RX_CAP.
- RX_CAP (1 cycle): latch bus_data_out → ACK.
- ACK (1 cycle): ack[g] = 1; resp_data = latched RX word (RX only); pointer = (g+1) mod requesters → IDLE.
- Latency, measured from the IDLE cycle that samples the request to the ack cycle, when status permits:
  - TX: 4 cycles.
  - RX: 5 cycles.
  - Minimum gap between consecutive acks: 5 (TX) or 6 (RX) cycles.
- Bus rules:
  - bus_read_enable and bus_write_enable are never high together.
  - Each is high for exactly one cycle per access.
  - bus_address and bus_data_in are 0 when both enables are low.
- Request data is latched at grant. Changing or dropping req_valid/req_data after grant does not affect the transaction; ack is still issued.
- A client must drop req_valid in the cycle after its ack, or it is treated as a new request.
- Simultaneous requests are resolved purely by the pointer. After an ack or a failed attempt, the winner has lowest priority.
- The pointer wraps from requesters-1 to 0.

Test Plan:
- Single TX:
  - Stimulus: client0 TX 'h0A; status 'b01.
  - Required: bus_write_enable@5 (status read), then bus_read_enable with bus_address 4 and bus_data_in 'h0A, then ack = 'b01 exactly 4 cycles after the request was sampled.
- Single RX:
  - Stimulus: client1 RX; status 'b10; UART returns 'h3E.
  - Required: ack = 'b10 5 cycles after the request was sampled, with resp_data = 'h3E in the ack cycle and 0 otherwise.
- Round robin:
  - Stimulus: clients 0 and 1 request TX continuously ('h11, 'h22); status 'b01.
  - Required: bus writes alternate 'h11, 'h22, 'h11, … and acks alternate 'b01, 'b10.
- Blocked op and retry:
  - Stimulus: client0 RX with status 'b00; client1 TX with status 'b01.
  - Required: client1 is acked while client0 gets no ack and no RX bus access. After status changes to 'b11, client0 is acked on a later retry.
- Mid-transaction reset:
  - Stimulus: assert reset during XFER.
  - Required: all outputs are 0 within the same cycle (asynchronously) and no ack is issued. After release, an outstanding request restarts from STATUS_REQ with the pointer at 0.
- Data stability:
  - Stimulus: client0 TX 'h55; change req_data to 'hAA one cycle after grant.
  - Required: bus_data_in = 'h55 in XFER.
